// File: rtl/uart_tx_seq_pkg.sv
// Shared definitions for the UART TX sequencer: state encoding, UART register
// map defaults, STATUS bit layout and the registered output bundle.
package uart_tx_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_MWAIT = 3'd2,
    ST_POLL  = 3'd3,
    ST_PWAIT = 3'd4,
    ST_WRITE = 3'd5,
    ST_NEXT  = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  localparam logic [31:0] UART_BASE_DEF = 32'h1000_0000;
  localparam logic [31:0] TXD_OFS_DEF   = 32'h0;
  localparam logic [31:0] STAT_OFS_DEF  = 32'h8;
  localparam logic [15:0] POLL_MAX_DEF  = 16'd50000;
  localparam int          STAT_BUSY_BIT = 0;

  // Everything the sequencer presents to the outside world, registered as one unit.
  typedef struct packed {
    logic        busy;
    logic        done;
    logic        mem_r_enable;
    logic [31:0] mem_r_addr;
    logic        uart_r_enable;
    logic [31:0] uart_r_addr;
    logic        uart_w_enable;
    logic [31:0] uart_w_addr;
    logic [31:0] uart_w_data;
  } seq_out_t;

  // Little-endian byte lane select.
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_seq_if.sv
// Control and bus signals between the UART TX sequencer (master) and the
// core / data memory / UART peripheral side (slave).
interface uart_tx_seq_if;
  logic        start_i;
  logic        abort_i;
  logic [31:0] src_addr_i;
  logic [15:0] len_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        irq_o;
  logic [31:0] mem_r_addr_o;
  logic        mem_r_enable_o;
  logic [31:0] mem_data_i;
  logic [31:0] uart_r_addr_o;
  logic        uart_r_enable_o;
  logic [31:0] uart_w_addr_o;
  logic        uart_w_enable_o;
  logic [31:0] uart_data_o;
  logic [31:0] uart_data_i;

  modport master (
    input  start_i, abort_i, src_addr_i, len_i, mem_data_i, uart_data_i,
    output busy_o, done_o, err_o, irq_o,
           mem_r_addr_o, mem_r_enable_o,
           uart_r_addr_o, uart_r_enable_o,
           uart_w_addr_o, uart_w_enable_o, uart_data_o
  );

  modport slave (
    output start_i, abort_i, src_addr_i, len_i, mem_data_i, uart_data_i,
    input  busy_o, done_o, err_o, irq_o,
           mem_r_addr_o, mem_r_enable_o,
           uart_r_addr_o, uart_r_enable_o,
           uart_w_addr_o, uart_w_enable_o, uart_data_o
  );
endinterface

// File: rtl/uart_tx_seq.sv
// Bus-master sequencer: streams a byte buffer from data memory into the UART
// TXDATA register, polling STATUS for tx idle before each byte.
module uart_tx_seq
  import uart_tx_seq_pkg::*;
#(
  parameter logic [31:0] UART_BASE = UART_BASE_DEF,
  parameter logic [31:0] TXD_OFS   = TXD_OFS_DEF,
  parameter logic [31:0] STAT_OFS  = STAT_OFS_DEF,
  parameter logic [15:0] POLL_MAX  = POLL_MAX_DEF
) (
  input logic           clk,
  input logic           rst,
  uart_tx_seq_if.master bus
);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] poll_q, poll_d;
  logic [7:0]  byte_q, byte_d;
  logic        err_q, err_d;
  logic        irq_q, irq_d;
  seq_out_t    out_q, out_d;

  logic        stat_busy;
  logic        unused_stat_bits;

  assign stat_busy        = bus.uart_data_i[STAT_BUSY_BIT];
  assign unused_stat_bits = ^bus.uart_data_i[31:STAT_BUSY_BIT+1];

  // Next-state and datapath updates.
  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    poll_d  = poll_q;
    byte_d  = byte_q;
    err_d   = err_q;
    irq_d   = irq_q;

    if (state_q != ST_IDLE && bus.abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start_i && !bus.abort_i) begin
            err_d = 1'b0;
            if (bus.len_i != 16'd0) begin
              addr_d  = bus.src_addr_i;
              cnt_d   = bus.len_i;
              irq_d   = 1'b0;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_FETCH: state_d = ST_MWAIT;
        ST_MWAIT: begin
          byte_d  = lane_byte(bus.mem_data_i, addr_q[1:0]);
          poll_d  = 16'd0;
          state_d = ST_POLL;
        end
        ST_POLL:  state_d = ST_PWAIT;
        ST_PWAIT: begin
          if (!stat_busy) begin
            state_d = ST_WRITE;
          end else if (poll_q == POLL_MAX - 16'd1) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            poll_d  = poll_q + 16'd1;
            state_d = ST_POLL;
          end
        end
        ST_WRITE: state_d = ST_NEXT;
        ST_NEXT: begin
          addr_d  = addr_q + 32'd1;
          cnt_d   = cnt_q - 16'd1;
          state_d = (cnt_q == 16'd1) ? ST_DONE : ST_FETCH;
        end
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end

    if (state_d == ST_DONE) irq_d = 1'b1;
  end

  // Outputs are decoded from the state being entered so they line up with it once registered.
  always_comb begin
    out_d      = '0;
    out_d.busy = (state_d != ST_IDLE) && (state_d != ST_DONE);
    out_d.done = (state_d == ST_DONE);
    case (state_d)
      ST_FETCH: begin
        out_d.mem_r_enable = 1'b1;
        out_d.mem_r_addr   = {addr_d[31:2], 2'b00};
      end
      ST_POLL: begin
        out_d.uart_r_enable = 1'b1;
        out_d.uart_r_addr   = UART_BASE + STAT_OFS;
      end
      ST_WRITE: begin
        out_d.uart_w_enable = 1'b1;
        out_d.uart_w_addr   = UART_BASE + TXD_OFS;
        out_d.uart_w_data   = {24'b0, byte_d};
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      poll_q  <= '0;
      byte_q  <= '0;
      err_q   <= 1'b0;
      irq_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      poll_q  <= poll_d;
      byte_q  <= byte_d;
      err_q   <= err_d;
      irq_q   <= irq_d;
      out_q   <= out_d;
    end
  end

  assign bus.busy_o          = out_q.busy;
  assign bus.done_o          = out_q.done;
  assign bus.err_o           = err_q;
  assign bus.irq_o           = irq_q;
  assign bus.mem_r_enable_o  = out_q.mem_r_enable;
  assign bus.mem_r_addr_o    = out_q.mem_r_addr;
  assign bus.uart_r_enable_o = out_q.uart_r_enable;
  assign bus.uart_r_addr_o   = out_q.uart_r_addr;
  assign bus.uart_w_enable_o = out_q.uart_w_enable;
  assign bus.uart_w_addr_o   = out_q.uart_w_addr;
  assign bus.uart_data_o     = out_q.uart_w_data;

endmodule
